// File: rtl/csla_seq_pkg.sv
// Shared definitions for the sequential carry-select adder controller:
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package csla_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/csla_icg_cell.sv
// Latch-based integrated clock gate: enable sampled while clk is low, ANDed
// with clk. test_en_i forces the clock on.
module csla_icg_cell (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic gclk_o
);

  logic en_l;

  always_latch begin
    if (!clk_i) en_l <= en_i | test_en_i;
  end

  assign gclk_o = clk_i & en_l;

endmodule

// File: rtl/param_csla.sv
// Combinational carry-select adder slice. APPROX>0 replaces the APPROX LSBs with
// a carry-free OR of the operands and drops cin; APPROX=0 gives an exact sum.
module param_csla #(
  parameter int unsigned W      = 8,
  parameter int unsigned APPROX = 0
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  localparam int unsigned NApx = (APPROX > W) ? W : APPROX;
  localparam int unsigned LoW  = (W + 1) / 2;
  localparam int unsigned HiW  = W - LoW;
  localparam logic [W-1:0] ApxMask = {W{1'b1}} >> (W - NApx);

  logic [W-1:0] a_m, b_m, exact;
  logic         c_m;

  assign a_m = a_i & ~ApxMask;
  assign b_m = b_i & ~ApxMask;
  assign c_m = (NApx == 0) ? cin_i : 1'b0;

  if (HiW == 0) begin : g_single
    assign {cout_o, exact} = {1'b0, a_m} + {1'b0, b_m} + (W + 1)'(c_m);
  end else begin : g_select
    logic [LoW:0] lo;
    logic [HiW:0] hi0, hi1;
    assign lo  = {1'b0, a_m[LoW-1:0]} + {1'b0, b_m[LoW-1:0]} + (LoW + 1)'(c_m);
    // Upper half precomputed for both carry values, picked by the low carry.
    assign hi0 = {1'b0, a_m[W-1:LoW]} + {1'b0, b_m[W-1:LoW]};
    assign hi1 = {1'b0, a_m[W-1:LoW]} + {1'b0, b_m[W-1:LoW]} + (HiW + 1)'(1);
    assign exact  = {lo[LoW] ? hi1[HiW-1:0] : hi0[HiW-1:0], lo[LoW-1:0]};
    assign cout_o = lo[LoW] ? hi1[HiW] : hi0[HiW];
  end

  assign sum_o = exact | ((a_i | b_i) & ApxMask);

endmodule

// File: rtl/csla_seq_adder_ctrl.sv
// Multi-cycle wide adder reusing one param_csla slice over NSLICES cycles.
// CSLA_SEQ_CLKGATE_EN: clock the datapath registers through csla_icg_cell.
module csla_seq_adder_ctrl
  import csla_seq_pkg::*;
#(
  parameter int unsigned TOTAL_W = 32,
  parameter int unsigned SLICE_W = 8,
  parameter int unsigned APPROX  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [TOTAL_W-1:0] a_i,
  input  logic [TOTAL_W-1:0] b_i,
  input  logic               cin_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [TOTAL_W-1:0] sum_o,
  output logic               cout_o,
  output logic               busy_o
);

  localparam int unsigned NSLICES = TOTAL_W / SLICE_W;
  localparam int unsigned IdxW    = (clog2(NSLICES) < 1) ? 1 : clog2(NSLICES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICES - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TOTAL_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d;
  logic              carry_q, carry_d, cout_q, cout_d;
  logic [SLICE_W-1:0] slice_sum;
  logic              slice_cout;
  logic              accept, load_en, dp_en;

  param_csla #(
    .W      (SLICE_W),
    .APPROX (APPROX)
  ) u_slice (
    .a_i    (op_a_q[SLICE_W-1:0]),
    .b_i    (op_b_q[SLICE_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  assign accept  = in_valid_i && (state_q == StIdle);
  assign load_en = accept || (state_q == StRun);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      StRun: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      op_a_d  = a_i;
      op_b_d  = b_i;
      carry_d = cin_i;
    end else if (state_q == StRun) begin
      op_a_d  = op_a_q >> SLICE_W;
      op_b_d  = op_b_q >> SLICE_W;
      carry_d = slice_cout;
      sum_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
      if (idx_q == LastIdx) cout_d = slice_cout;
    end
  end

`ifdef CSLA_SEQ_CLKGATE_EN
  logic gclk;

  csla_icg_cell u_icg (
    .clk_i     (clk),
    .en_i      (load_en),
    .test_en_i (1'b0),
    .gclk_o    (gclk)
  );

  // Gated clock only pulses when load_en is set, so the load enable is implicit.
  assign dp_en = 1'b1;

  always_ff @(posedge gclk or negedge rst_n) begin
`else
  assign dp_en = load_en;

  always_ff @(posedge clk or negedge rst_n) begin
`endif
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (dp_en) begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;

endmodule

// File: tb/tb_csla_seq_adder_ctrl.sv
// Self-checking bench for csla_seq_adder_ctrl (TOTAL_W=32, SLICE_W=8, APPROX=0):
// vector table, corner-case sequences and random ops against a scoreboard queue.
module tb_csla_seq_adder_ctrl;

  localparam int unsigned TW = 32;
  localparam int unsigned SW = 8;
  localparam int unsigned NS = TW / SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [TW-1:0] a, b, sum;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [TW-1:0] s;
    logic          c;
  } res_t;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic [TW-1:0] exp_sum;
    logic          exp_cout;
  } vec_t;

  res_t sb_q[$];
  vec_t vecs[6];

  csla_seq_adder_ctrl #(
    .TOTAL_W (TW),
    .SLICE_W (SW),
    .APPROX  (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

`ifdef CSLA_SEQ_CLKGATE_EN
  int gclk_bad = 0;
  always @(posedge dut.gclk) begin
    if (rst_n && ((!busy && !in_valid) || out_valid)) gclk_bad++;
  end
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set in IDLE; returns #1 after the accepting edge.
  task automatic issue(input logic [TW-1:0] va, input logic [TW-1:0] vb, input logic vc,
                       input logic [TW-1:0] es, input logic ec);
    int w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) chk("issue_ready_timeout", 64'(in_ready), 64'd1);
    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    sb_q.push_back('{s: es, c: ec});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_cmp(input string tag);
    res_t r;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      r = sb_q.pop_front();
      chk({tag, "_sum"}, 64'(sum), 64'(r.s));
      chk({tag, "_cout"}, 64'(cout), 64'(r.c));
    end
  endtask

  task automatic wait_valid(output int edges, output bit busy_ok);
    edges = 0;
    busy_ok = 1'b1;
    while (!out_valid && edges < 50) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      edges++;
    end
  endtask

  task automatic collect(input string tag);
    int  e;
    bit  bok;
    wait_valid(e, bok);
    chk({tag, "_latency"}, 64'(e), 64'(NS));
    chk({tag, "_busy_run"}, 64'(bok), 64'd1);
    pop_cmp(tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy_drop"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [TW-1:0] ra, rb;
    logic          rc;
    logic [TW:0]   rsum;
    int            e;
    bit            bok;
    logic [TW-1:0] held_sum;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[5] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout);
      collect($sformatf("vec%0d", i));
    end

    // DONE held with out_ready low while new operands are offered.
    issue(32'hCAFE_0000, 32'h0000_BEEF, 1'b0, 32'hCAFE_BEEF, 1'b0);
    wait_valid(e, bok);
    chk("hold_latency", 64'(e), 64'(NS));
    held_sum = sum;
    a = 32'h1111_1111;
    b = 32'h2222_2222;
    cin = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("hold%0d_sum_stable", k), 64'(sum), 64'(held_sum));
    end
    pop_cmp("hold");
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("hold_no_capture", 64'(busy), 64'd0);

    // Reset asserted mid-RUN at idx=2.
    issue(32'hAAAA_AAAA, 32'h1111_1111, 1'b0, 32'hBBBB_BBBB, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    issue(32'd1, 32'd1, 1'b0, 32'd2, 1'b0);
    collect("post_rst");

    // Back-to-back: second accept on the edge after the handshake.
    a = 32'h0F0F_0F0F;
    b = 32'hF0F0_F0F0;
    cin = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    sb_q.push_back('{s: 32'h0000_0000, c: 1'b1});
    tick();
    chk("b2b_first_accept", 64'(busy), 64'd1);
    a = 32'h7FFF_FFFF;
    b = 32'h0000_0001;
    cin = 1'b0;
    wait_valid(e, bok);
    chk("b2b_first_latency", 64'(e), 64'(NS));
    pop_cmp("b2b_first");
    tick();
    chk("b2b_idle_after_hs", 64'(in_ready), 64'd1);
    sb_q.push_back('{s: 32'h8000_0000, c: 1'b0});
    tick();
    chk("b2b_second_accept", 64'(busy), 64'd1);
    in_valid = 1'b0;
    wait_valid(e, bok);
    chk("b2b_second_latency", 64'(e), 64'(NS));
    pop_cmp("b2b_second");
    tick();
    out_ready = 1'b0;

    for (int n = 0; n < 150; n++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      rsum = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      issue(ra, rb, rc, rsum[TW-1:0], rsum[TW]);
      collect($sformatf("rand%0d", n));
    end

`ifdef CSLA_SEQ_CLKGATE_EN
    chk("gclk_idle_done_toggles", 64'(gclk_bad), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
